dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane.sv | 41 ++++
 rtl/dmem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory controller:
//               FSM state encoding, full-word byte-enable and the default
//               ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Two-bit state encoding kept explicit so the values are stable in
    // waveforms and legacy netlists.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam logic [3:0] BE_WORD                = 4'b1111;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane
// Description : Byte-lane helper for the data-memory controller. Builds the
//               byte-write enable and replicated write data, and extracts a
//               zero-extended byte from a read word.
// Ports       : i_wr_sel  - address bits [1:0] of the store
//               i_wr_byte - store byte (WriteData[7:0])
//               i_rd_sel  - address bits [1:0] of the load
//               i_rd_word - word returned by memory
//               o_be      - one-hot byte enable for the store lane
//               o_wdata   - store byte replicated on all four lanes
//               o_rd_byte - selected load byte, zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane (
    input  logic [1:0]  i_wr_sel,
    input  logic [7:0]  i_wr_byte,
    input  logic [1:0]  i_rd_sel,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rd_byte
);

    assign o_be    = 4'b0001 << i_wr_sel;
    // Replicating the byte lets memory pick it up on whichever lane is enabled.
    assign o_wdata = {4{i_wr_byte}};

    always_comb begin
        o_rd_byte = 32'h0;
        case (i_rd_sel)
            2'd0:    o_rd_byte = {24'h0, i_rd_word[7:0]};
            2'd1:    o_rd_byte = {24'h0, i_rd_word[15:8]};
            2'd2:    o_rd_byte = {24'h0, i_rd_word[23:16]};
            default: o_rd_byte = {24'h0, i_rd_word[31:24]};
        endcase
    end

endmodule : dmem_lane
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory access controller between a single-issue datapath
//               and a req/ack memory. One access at a time: IDLE -> REQ ->
//               DONE -> IDLE. The datapath is stalled while the access is
//               open and retires the instruction in DONE. A wait counter
//               aborts an access that is never acknowledged.
// Parameters  : TIMEOUT_CYCLES - max REQ cycles waiting for mem_ack
// Macros      : DMEM_ALIGN_CHECK_EN - when defined, a misaligned word access
//               is refused without touching memory and raises MemFault.
// Ports       : clk, reset (sync, active-high)
//               MemRead, MemWrite, MemByte, ALUResult, WriteData - datapath
//               ReadData, Stall, MemFault                         - datapath
//               mem_req, mem_we, mem_addr, mem_wdata, mem_be      - to memory
//               mem_ack, mem_rdata                                - from memory
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemByte,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int                 c_cnt_w    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    dmem_state_e        state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic [31:0]        addr_q,  addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q,    be_d;
    logic               we_q,    we_d;
    logic               byte_q,  byte_d;
    logic [1:0]         lane_q,  lane_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               fault_q, fault_d;

    logic               w_access;
    logic               w_misaligned;
    logic [3:0]         w_be_byte;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rd_byte;

    assign w_access = MemRead | MemWrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = ~MemByte & (ALUResult[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    dmem_lane u_lane (
        .i_wr_sel  (ALUResult[1:0]),
        .i_wr_byte (WriteData[7:0]),
        .i_rd_sel  (lane_q),
        .i_rd_word (mem_rdata),
        .o_be      (w_be_byte),
        .o_wdata   (w_wdata_rep),
        .o_rd_byte (w_rd_byte)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        byte_d  = byte_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_misaligned) begin
                        // Refused access: skip memory entirely, fault in DONE.
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        if (!MemWrite) begin
                            rdata_d = 32'h0;
                        end
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        addr_d  = {ALUResult[31:2], 2'b00};
                        wdata_d = MemByte ? w_wdata_rep : WriteData;
                        be_d    = MemByte ? w_be_byte : BE_WORD;
                        we_d    = MemWrite;     // write wins when both are set
                        byte_d  = MemByte;
                        lane_d  = ALUResult[1:0];
                    end
                end
            end
            ST_REQ: begin
                // An ack in the last allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = byte_q ? w_rd_byte : mem_rdata;
                    end
                end else if (cnt_q == c_cnt_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_DONE: begin
                // Instruction retires here; its request lines are still up,
                // so they must not re-trigger an access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= 2'b00;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // mem_req is a pure state decode, so a reset mid-access drops it at once
    // and any late ack arrives while IDLE and is ignored.
    assign mem_req   = (state_q == ST_REQ);
    assign Stall     = ((state_q == ST_IDLE) & w_access & ~w_misaligned) | (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadData  = rdata_q;
    assign MemFault  = fault_q;

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl (TIMEOUT_CYCLES = 4).
//               Expected load results, fault flag and stall length are pushed
//               to a scoreboard queue when an access is issued and popped
//               when the controller reaches DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        MemByte;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MemFault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rdata;
    int          n_checks;
    int          n_fail;

    dmem_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemByte   (MemByte),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemFault  (MemFault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access, act as memory (ack in REQ cycle ack_at, 0 = never),
    // and score the result when DONE is reached.
    task automatic run_access(input logic rd, input logic wr, input logic byt,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrd, input int ack_at);
        exp_t        e;
        exp_t        got_e;
        int          n_req;
        int          n_stall;
        bit          done;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;

        exp_addr = {addr[31:2], 2'b00};
        exp_be   = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        exp_wd   = byt ? {4{wdata[7:0]}} : wdata;

        e.fault = (ack_at == 0);
        e.stall = 1 + ((ack_at == 0) ? TIMEOUT : ack_at);
        if (wr)               e.rdata = model_rdata;
        else if (ack_at == 0) e.rdata = 32'h0;
        else if (byt)         e.rdata = (mrd >> (8 * addr[1:0])) & 32'hFF;
        else                  e.rdata = mrd;
        exp_q.push_back(e);
        model_rdata = e.rdata;

        MemRead   = rd;
        MemWrite  = wr;
        MemByte   = byt;
        ALUResult = addr;
        WriteData = wdata;
        n_req     = 0;
        n_stall   = 0;
        done      = 0;
        #1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (Stall) n_stall++;
            if (mem_req) begin
                n_req++;
                check_eq("mem_addr", mem_addr, exp_addr);
                check_eq("mem_we", 32'(mem_we), 32'(wr));
                if (wr) begin
                    check_eq("mem_be", 32'(mem_be), 32'(exp_be));
                    check_eq("mem_wdata", mem_wdata, exp_wd);
                end
                mem_ack   = (n_req == ack_at);
                mem_rdata = (n_req == ack_at) ? mrd : 32'h0BAD_0BAD;
            end else if (cyc > 0 && !Stall) begin
                done    = 1;
                mem_ack = 1'b0;
            end
            if (!done) tick();
        end

        got_e = exp_q.pop_front();
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_bound: access at 0x%08h never reached DONE", addr);
        end else begin
            check_eq("ReadData", ReadData, got_e.rdata);
            check_eq("MemFault", 32'(MemFault), 32'(got_e.fault));
            check_eq("stall_cycles", 32'(n_stall), 32'(got_e.stall));
            // Request still held through DONE: must not open a new access.
            tick();
            check_eq("no_restart_req", 32'(mem_req), 32'h0);
            check_eq("fault_pulse_end", 32'(MemFault), 32'h0);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check_eq("idle_stall", 32'(Stall), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rnd_rd;
        logic        rnd_byt;
        logic [31:0] rnd_addr;

        n_checks    = 0;
        n_fail      = 0;
        model_rdata = 32'h0;
        reset       = 1'b1;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemByte     = 1'b0;
        ALUResult   = 32'h0;
        WriteData   = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        tick();
        tick();

        // Reset values
        check_eq("rst_ReadData", ReadData, 32'h0);
        check_eq("rst_Stall", 32'(Stall), 32'h0);
        check_eq("rst_MemFault", 32'(MemFault), 32'h0);
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_mem_be", 32'(mem_be), 32'h0);
        reset = 1'b0;

        // Reset in the 2nd REQ cycle, late ack one cycle after
        MemRead   = 1'b1;
        ALUResult = 32'h500;
        tick();
        check_eq("abort_req1", 32'(mem_req), 32'h1);
        tick();
        check_eq("abort_req2", 32'(mem_req), 32'h1);
        reset = 1'b1;
        tick();
        check_eq("abort_req_after_rst", 32'(mem_req), 32'h0);
        reset     = 1'b0;
        MemRead   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check_eq("abort_stall", 32'(Stall), 32'h0);
        tick();
        mem_ack = 1'b0;
        check_eq("abort_ReadData", ReadData, 32'h0);
        check_eq("abort_mem_req", 32'(mem_req), 32'h0);
        check_eq("abort_MemFault", 32'(MemFault), 32'h0);

        // Stray ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check_eq("stray_ReadData", ReadData, model_rdata);
        check_eq("stray_mem_req", 32'(mem_req), 32'h0);

        // Directed scenarios
        run_access(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        run_access(0, 1, 1, 32'h203, 32'h12345678, 32'h0, 1);
        run_access(1, 0, 1, 32'h302, 32'h0, 32'hAABBCCDD, 2);
        run_access(1, 0, 0, 32'h480, 32'h0, 32'h11111111, 0);
        run_access(1, 0, 0, 32'h700, 32'h0, 32'h5A5A5A5A, 1);
        run_access(0, 1, 0, 32'h600, 32'hA5A5A5A5, 32'h0, 0);
        run_access(1, 1, 0, 32'h400, 32'h87654321, 32'h99999999, 2);
        run_access(1, 0, 0, 32'h800, 32'h0, 32'h01020304, TIMEOUT);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned word write: refused, single fault pulse, never stalled
        MemWrite  = 1'b1;
        MemByte   = 1'b0;
        ALUResult = 32'h101;
        WriteData = 32'hFEEDFACE;
        #1;
        check_eq("mis_wr_stall0", 32'(Stall), 32'h0);
        tick();
        check_eq("mis_wr_req", 32'(mem_req), 32'h0);
        check_eq("mis_wr_fault", 32'(MemFault), 32'h1);
        check_eq("mis_wr_stall1", 32'(Stall), 32'h0);
        MemWrite = 1'b0;
        tick();
        check_eq("mis_wr_fault_end", 32'(MemFault), 32'h0);
        check_eq("mis_wr_req_end", 32'(mem_req), 32'h0);
        // Misaligned word read clears ReadData
        MemRead   = 1'b1;
        ALUResult = 32'h902;
        tick();
        MemRead     = 1'b0;
        model_rdata = 32'h0;
        check_eq("mis_rd_fault", 32'(MemFault), 32'h1);
        check_eq("mis_rd_ReadData", ReadData, 32'h0);
        tick();
`else
        // Misaligned word access ignores the low address bits
        run_access(1, 0, 0, 32'h101, 32'h0, 32'h13572468, 2);
        run_access(0, 1, 0, 32'h10B, 32'h2468ACE0, 32'h0, 1);
`endif

        // Random mix of byte/word loads and stores
        for (int i = 0; i < 8; i++) begin
            rnd_rd   = 1'($urandom_range(0, 1));
            rnd_byt  = 1'($urandom_range(0, 1));
            rnd_addr = $urandom;
            if (!rnd_byt) rnd_addr[1:0] = 2'b00;
            run_access(rnd_rd, ~rnd_rd, rnd_byt, rnd_addr, $urandom, $urandom,
                       $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_ctrl
`default_nettype wire
